mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage pipeline; sits between the EX/MEM register and the word-wide data memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
- Sub-word stores use a 2-cycle read-modify-write. The memory has only a word write enable and no byte lanes.
- Registers load results toward writeback, flags misaligned accesses, and drives STALL back to the pipeline during the RMW.

Parameters:
- ADDR_W, 32, byte-address width; DM_A upper bits are passed through unchanged.
- SUPPRESS_MISALIGNED, 1, 1 = misaligned access issues no write and returns 0; 0 = force address alignment and proceed.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- VALID_M  in  1  MEM-stage instruction valid
- MEMREAD_M  in  1  load op
- MEMWRITE_M  in  1  store op
- FUNCT3_M  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDR_M  in  ADDR_W  byte address (ALU result)
- WDATA_M  in  32  store data (rs2)
- DM_RD  in  32  data memory combinational read word
- DM_A  out  ADDR_W  memory byte address, always {ADDR_M[ADDR_W-1:2],2'b00}
- DM_WD  out  32  memory write word
- DM_WE  out  1  memory write enable, single-cycle pulse
- STALL  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- LOAD_DATA_W  out  32  registered extended load result
- LOAD_VALID_W  out  1  registered: LOAD_DATA_W valid
- MISALIGN_W  out  1  registered: previous op was misaligned

Behaviour:
- Reset: FSM=IDLE. LOAD_DATA_W=0, LOAD_VALID_W=0, MISALIGN_W=0, merge register=0.
- Reset: DM_WE=0 and STALL=0 combinationally while RST_N=0.
- Reset asserted while in MERGE: the write is abandoned, and the return is to IDLE with no DM_WE.
- Misalign rule: H/HU with ADDR_M[0]=1; W with ADDR_M[1:0]!=0. B never misaligns.
- FSM has two states, IDLE and MERGE.
- IDLE, VALID_M=0 or no op: DM_WE=0, STALL=0. Next edge: LOAD_VALID_W=0, MISALIGN_W=0.
- IDLE, SW aligned: DM_WE=1, DM_WD=WDATA_M in the same cycle; no stall.
- IDLE, SB/SH aligned: STALL=1, DM_WE=0.
  - Merge word = DM_RD with the byte lane(s) at ADDR_M[1:0] replaced by WDATA_M[7:0] or [15:0].
  - Merge word is captured at the edge; FSM -> MERGE.
- MERGE: DM_WE=1, DM_WD=merge register, STALL=0; FSM -> IDLE at the next edge.
  - Inputs are held by the stalled EX/MEM, so DM_A is unchanged.
- Loads (IDLE):
  - Select the byte/half from DM_RD by ADDR_M[1:0].
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Register into LOAD_DATA_W at the next edge; LOAD_VALID_W=1 for one cycle. Latency is 1 cycle.
- Misaligned op with SUPPRESS_MISALIGNED=1: no DM_WE, no stall, LOAD_DATA_W=0, LOAD_VALID_W=0 (load). MISALIGN_W=1 for one cycle.
- Misaligned op with SUPPRESS_MISALIGNED=0: low address bits are forced to alignment and the op proceeds. MISALIGN_W=1 is still flagged.
- MEMREAD_M and MEMWRITE_M both 1: the store is performed, the load is ignored, LOAD_VALID_W=0.
- Undefined FUNCT3 (011/110/111): treated as no op; MISALIGN_W=0.
- Back-to-back sub-word stores:
  - Each costs 2 cycles.
  - The second store's read phase sees the first store's merged word, because the write occurs in MERGE before IDLE re-reads.
- Load directly after a store to the same word: DM_RD already reflects the written word, so no forwarding is needed.

Optional Feature:
- Macro: LSU_PERF_EN.
- When defined: extra outputs RMW_COUNT[15:0] and MISALIGN_COUNT[15:0].
  - RMW_COUNT increments on each MERGE entry.
  - MISALIGN_COUNT increments on each misaligned op.
  - Both saturate at 0xFFFF and are cleared by RST_N.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Preload word0=0x000005E8. LW addr 0x0 -> next cycle LOAD_DATA_W=0x000005E8, LOAD_VALID_W=1, STALL never high.
- Preload word1=0x0000067F. LB addr 0x4 -> 0x0000007F. LB addr 0x5 -> 0x00000006. LH addr 0x4 -> 0x0000067F.
- Preload word2=0x80FF0000. LB addr 0xA -> 0xFFFFFFFF. LBU addr 0xA -> 0x000000FF. LH addr 0xA -> 0xFFFF80FF.
- SB 0xAB to addr 0x1 over word0=0x000005E8:
  - STALL=1 for 1 cycle, then DM_WE=1 with DM_WD=0x0000ABE8.
  - Follow-up LW addr 0x0 -> 0x0000ABE8.
- SW addr 0x6 -> MISALIGN_W=1 for one cycle, DM_WE never asserted, word1 unchanged.
  - With LSU_PERF_EN, MISALIGN_COUNT=1.
- SH addr 0x2 with RST_N pulsed low during MERGE -> DM_WE stays 0, FSM in IDLE, all registered outputs 0, memory word unchanged.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Bundles the MEM-stage pipeline controls, the data-memory port and the
// writeback-side results of the load/store unit into one interface.
// slave = the LSU itself; master = the pipeline and memory around it.
// Optional LSU_PERF_EN adds RMW_COUNT and MISALIGN_COUNT to the bundle.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              VALID_M;
  logic              MEMREAD_M;
  logic              MEMWRITE_M;
  logic [2:0]        FUNCT3_M;
  logic [ADDR_W-1:0] ADDR_M;
  logic [31:0]       WDATA_M;
  logic [31:0]       DM_RD;
  logic [ADDR_W-1:0] DM_A;
  logic [31:0]       DM_WD;
  logic              DM_WE;
  logic              STALL;
  logic [31:0]       LOAD_DATA_W;
  logic              LOAD_VALID_W;
  logic              MISALIGN_W;
`ifdef LSU_PERF_EN
  logic [15:0]       RMW_COUNT;
  logic [15:0]       MISALIGN_COUNT;

  modport slave (
    input  VALID_M, MEMREAD_M, MEMWRITE_M, FUNCT3_M, ADDR_M, WDATA_M, DM_RD,
    output DM_A, DM_WD, DM_WE, STALL, LOAD_DATA_W, LOAD_VALID_W, MISALIGN_W,
    output RMW_COUNT, MISALIGN_COUNT
  );
  modport master (
    output VALID_M, MEMREAD_M, MEMWRITE_M, FUNCT3_M, ADDR_M, WDATA_M, DM_RD,
    input  DM_A, DM_WD, DM_WE, STALL, LOAD_DATA_W, LOAD_VALID_W, MISALIGN_W,
    input  RMW_COUNT, MISALIGN_COUNT
  );
`else
  modport slave (
    input  VALID_M, MEMREAD_M, MEMWRITE_M, FUNCT3_M, ADDR_M, WDATA_M, DM_RD,
    output DM_A, DM_WD, DM_WE, STALL, LOAD_DATA_W, LOAD_VALID_W, MISALIGN_W
  );
  modport master (
    output VALID_M, MEMREAD_M, MEMWRITE_M, FUNCT3_M, ADDR_M, WDATA_M, DM_RD,
    input  DM_A, DM_WD, DM_WE, STALL, LOAD_DATA_W, LOAD_VALID_W, MISALIGN_W
  );
`endif
endinterface

// File: rtl/mem_stage_lsu.sv
// Purpose: RV32I MEM-stage load/store unit over a word-only data memory.
// Latency: loads 1 cycle to LOAD_DATA_W; SW same cycle; SB/SH 2-cycle RMW.
// Backpressure: STALL high for the read phase of a sub-word store only.
// Ports: CLK, RST_N (async active-low); bus (mem_stage_lsu_if.slave) carries
//   pipeline inputs (VALID_M, MEMREAD_M, MEMWRITE_M, FUNCT3_M, ADDR_M,
//   WDATA_M), memory port (DM_RD in; DM_A, DM_WD, DM_WE out) and results
//   (STALL, LOAD_DATA_W, LOAD_VALID_W, MISALIGN_W).
// Optional: define LSU_PERF_EN for saturating RMW_COUNT / MISALIGN_COUNT.
module mem_stage_lsu #(
  parameter int ADDR_W              = 32,
  parameter bit SUPPRESS_MISALIGNED = 1'b1
) (
  input logic           CLK,
  input logic           RST_N,
  mem_stage_lsu_if.slave bus
);

  typedef enum logic {IDLE, MERGE} state_e;

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misalign_q, misalign_d;

  logic        is_b, is_h, is_w, is_unsigned;
  logic        op_vld, is_store, is_load, misalign, proceed;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext, merge_word, wd_c;
  logic        we_c, stall_c;

  // 000/100 byte, 001/101 half, 010 word; 011/110/111 decode to nothing.
  assign is_b        = (bus.FUNCT3_M[1:0] == 2'b00);
  assign is_h        = (bus.FUNCT3_M[1:0] == 2'b01);
  assign is_w        = (bus.FUNCT3_M == 3'b010);
  assign is_unsigned = bus.FUNCT3_M[2];

  assign op_vld   = bus.VALID_M && (is_b || is_h || is_w) &&
                    (bus.MEMREAD_M || bus.MEMWRITE_M);
  // A combined read+write is executed as a store only.
  assign is_store = bus.MEMWRITE_M;
  assign is_load  = bus.MEMREAD_M && !bus.MEMWRITE_M;
  assign misalign = op_vld && ((is_h && bus.ADDR_M[0]) ||
                               (is_w && (bus.ADDR_M[1:0] != 2'b00)));
  assign proceed  = op_vld && (!misalign || !SUPPRESS_MISALIGNED);

  // Lane offset with the low bits forced to the access size; identical to
  // ADDR_M[1:0] for aligned ops, and realigns misaligned ones when they
  // are allowed to proceed.
  assign off = is_w ? 2'b00 : (is_h ? {bus.ADDR_M[1], 1'b0} : bus.ADDR_M[1:0]);

  assign byte_sel = bus.DM_RD[{off, 3'b000} +: 8];
  assign half_sel = bus.DM_RD[{off[1], 4'b0000} +: 16];

  always_comb begin
    if (is_w) begin
      load_ext = bus.DM_RD;
    end else if (is_h) begin
      load_ext = {{16{!is_unsigned && half_sel[15]}}, half_sel};
    end else begin
      load_ext = {{24{!is_unsigned && byte_sel[7]}}, byte_sel};
    end
  end

  always_comb begin
    merge_word = bus.DM_RD;
    if (is_h) begin
      merge_word[{off[1], 4'b0000} +: 16] = bus.WDATA_M[15:0];
    end else begin
      merge_word[{off, 3'b000} +: 8] = bus.WDATA_M[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    load_data_d  = '0;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    we_c         = 1'b0;
    stall_c      = 1'b0;
    wd_c         = bus.WDATA_M;
    case (state_q)
      IDLE: begin
        misalign_d = misalign;
        if (proceed && is_store) begin
          if (is_w) begin
            we_c = 1'b1;
          end else begin
            // Read phase: capture the merged word, write it next cycle.
            stall_c = 1'b1;
            merge_d = merge_word;
            state_d = MERGE;
          end
        end else if (proceed && is_load) begin
          load_data_d  = load_ext;
          load_valid_d = 1'b1;
        end
      end
      MERGE: begin
        // Inputs are frozen by the stall, so DM_A still points at the word.
        we_c    = 1'b1;
        wd_c    = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // Gate with RST_N so an in-flight RMW never writes while reset is held.
  assign bus.DM_A         = {bus.ADDR_M[ADDR_W-1:2], 2'b00};
  assign bus.DM_WD        = wd_c;
  assign bus.DM_WE        = we_c && RST_N;
  assign bus.STALL        = stall_c && RST_N;
  assign bus.LOAD_DATA_W  = load_data_q;
  assign bus.LOAD_VALID_W = load_valid_q;
  assign bus.MISALIGN_W   = misalign_q;

`ifdef LSU_PERF_EN
  logic [15:0] rmw_cnt_q, rmw_cnt_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    rmw_cnt_d = rmw_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (state_q == IDLE && state_d == MERGE && rmw_cnt_q != 16'hFFFF) begin
      rmw_cnt_d = rmw_cnt_q + 16'd1;
    end
    if (state_q == IDLE && misalign && mis_cnt_q != 16'hFFFF) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rmw_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      rmw_cnt_q <= rmw_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.RMW_COUNT      = rmw_cnt_q;
  assign bus.MISALIGN_COUNT = mis_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: word memory model behind the LSU,
// hand-computed expected load/merge values, one summary line at the end.
module tb_mem_stage_lsu;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(
    .ADDR_W(32),
    .SUPPRESS_MISALIGNED(1'b1)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // Word-wide data memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_dat = 32'd0;

  assign bus.DM_RD = mem[bus.DM_A[5:2]];

  always @(posedge CLK) begin
    if (pl_we) mem[pl_idx] <= pl_dat;
    else if (bus.DM_WE) mem[bus.DM_A[5:2]] <= bus.DM_WD;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.VALID_M    = v;
    bus.MEMREAD_M  = rd;
    bus.MEMWRITE_M = wr;
    bus.FUNCT3_M   = f3;
    bus.ADDR_M     = a;
    bus.WDATA_M    = wd;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pl_we  = 1'b1;
    pl_idx = idx[3:0];
    pl_dat = d;
    @(posedge CLK);
    #1;
    pl_we  = 1'b0;
  endtask

  // Issue one load on a negedge and check its registered result.
  task automatic load_chk(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp);
    @(negedge CLK);
    set_op(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    #1;
    check({tag, " stall"}, {31'b0, bus.STALL}, 32'd0);
    check({tag, " we"}, {31'b0, bus.DM_WE}, 32'd0);
    check({tag, " dm_a"}, bus.DM_A, {a[31:2], 2'b00});
    @(posedge CLK);
    #1;
    check({tag, " data"}, bus.LOAD_DATA_W, exp);
    check({tag, " valid"}, {31'b0, bus.LOAD_VALID_W}, 32'd1);
    check({tag, " misalign"}, {31'b0, bus.MISALIGN_W}, 32'd0);
  endtask

  initial begin
    // Reset held with a store request present: nothing may reach memory.
    set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF);
    #1;
    check("rst we", {31'b0, bus.DM_WE}, 32'd0);
    check("rst stall", {31'b0, bus.STALL}, 32'd0);
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    preload(0, 32'h0000_05E8);
    preload(1, 32'h0000_067F);
    preload(2, 32'h80FF_0000);
    check("rst ld_data", bus.LOAD_DATA_W, 32'd0);
    check("rst ld_valid", {31'b0, bus.LOAD_VALID_W}, 32'd0);
    check("rst misalign", {31'b0, bus.MISALIGN_W}, 32'd0);
    check("rst mem0", mem[0], 32'h0000_05E8);
`ifdef LSU_PERF_EN
    check("rst rmw_cnt", {16'h0, bus.RMW_COUNT}, 32'd0);
    check("rst mis_cnt", {16'h0, bus.MISALIGN_COUNT}, 32'd0);
`endif
    @(negedge CLK);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    RST_N = 1'b1;

    // Loads with sign/zero extension.
    load_chk("lw 0", 3'b010, 32'h0, 32'h0000_05E8);
    load_chk("lb 4", 3'b000, 32'h4, 32'h0000_007F);
    load_chk("lb 5", 3'b000, 32'h5, 32'h0000_0006);
    load_chk("lh 4", 3'b001, 32'h4, 32'h0000_067F);
    load_chk("lb a", 3'b000, 32'hA, 32'hFFFF_FFFF);
    load_chk("lbu a", 3'b100, 32'hA, 32'h0000_00FF);
    load_chk("lh a", 3'b001, 32'hA, 32'hFFFF_80FF);
    load_chk("lhu a", 3'b101, 32'hA, 32'h0000_80FF);
    load_chk("lb b", 3'b000, 32'hB, 32'hFFFF_FF80);

    // Undefined funct3 (011) at an odd address: no op, no misalign.
    @(negedge CLK);
    set_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h1, 32'h0);
    @(posedge CLK);
    #1;
    check("undef valid", {31'b0, bus.LOAD_VALID_W}, 32'd0);
    check("undef misalign", {31'b0, bus.MISALIGN_W}, 32'd0);

    // SB 0xAB to byte 1 of word0: one stall cycle, then the merged write.
    @(negedge CLK);
    set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h1, 32'h0000_00AB);
    #1;
    check("sb rd stall", {31'b0, bus.STALL}, 32'd1);
    check("sb rd we", {31'b0, bus.DM_WE}, 32'd0);
    @(posedge CLK);
    #1;
    check("sb wr stall", {31'b0, bus.STALL}, 32'd0);
    check("sb wr we", {31'b0, bus.DM_WE}, 32'd1);
    check("sb wr wd", bus.DM_WD, 32'h0000_ABE8);
    @(posedge CLK);
    #1;
    check("sb mem0", mem[0], 32'h0000_ABE8);
    load_chk("lw 0 after sb", 3'b010, 32'h0, 32'h0000_ABE8);

    // Misaligned LW: suppressed, data cleared, flag for one cycle.
    @(negedge CLK);
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
    #1;
    check("mlw stall", {31'b0, bus.STALL}, 32'd0);
    @(posedge CLK);
    #1;
    check("mlw data", bus.LOAD_DATA_W, 32'd0);
    check("mlw valid", {31'b0, bus.LOAD_VALID_W}, 32'd0);
    check("mlw misalign", {31'b0, bus.MISALIGN_W}, 32'd1);
`ifdef LSU_PERF_EN
    check("mlw mis_cnt", {16'h0, bus.MISALIGN_COUNT}, 32'd1);
`endif

    // Misaligned SW at 0x6: no write, word1 unchanged.
    @(negedge CLK);
    set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF);
    #1;
    check("msw we", {31'b0, bus.DM_WE}, 32'd0);
    check("msw stall", {31'b0, bus.STALL}, 32'd0);
    @(posedge CLK);
    #1;
    check("msw misalign", {31'b0, bus.MISALIGN_W}, 32'd1);
    check("msw mem1", mem[1], 32'h0000_067F);
`ifdef LSU_PERF_EN
    check("msw mis_cnt", {16'h0, bus.MISALIGN_COUNT}, 32'd2);
`endif
    @(negedge CLK);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    check("msw misalign clr", {31'b0, bus.MISALIGN_W}, 32'd0);

    // SH 0xBEEF to upper half of word1.
    @(negedge CLK);
    set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h6, 32'h1234_BEEF);
    #1;
    check("sh rd stall", {31'b0, bus.STALL}, 32'd1);
    @(posedge CLK);
    #1;
    check("sh wr we", {31'b0, bus.DM_WE}, 32'd1);
    check("sh wr wd", bus.DM_WD, 32'hBEEF_067F);
    @(posedge CLK);
    #1;
    check("sh mem1", mem[1], 32'hBEEF_067F);
`ifdef LSU_PERF_EN
    check("sh rmw_cnt", {16'h0, bus.RMW_COUNT}, 32'd2);
`endif
    load_chk("lw 4 after sh", 3'b010, 32'h4, 32'hBEEF_067F);
    load_chk("lh 6", 3'b001, 32'h6, 32'hFFFF_BEEF);
    load_chk("lhu 6", 3'b101, 32'h6, 32'h0000_BEEF);

    // Read and write together: store wins, no load result.
    @(negedge CLK);
    set_op(1'b1, 1'b1, 1'b1, 3'b010, 32'h8, 32'h1234_5678);
    #1;
    check("rw we", {31'b0, bus.DM_WE}, 32'd1);
    check("rw wd", bus.DM_WD, 32'h1234_5678);
    check("rw stall", {31'b0, bus.STALL}, 32'd0);
    @(posedge CLK);
    #1;
    check("rw valid", {31'b0, bus.LOAD_VALID_W}, 32'd0);
    check("rw mem2", mem[2], 32'h1234_5678);

    // SH to 0x2 with reset pulsed during MERGE: write abandoned.
    @(negedge CLK);
    set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h2, 32'h0000_1234);
    #1;
    check("shr rd stall", {31'b0, bus.STALL}, 32'd1);
    @(posedge CLK);
    #1;
    check("shr merge we", {31'b0, bus.DM_WE}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("shr rst we", {31'b0, bus.DM_WE}, 32'd0);
    check("shr rst stall", {31'b0, bus.STALL}, 32'd0);
    check("shr rst data", bus.LOAD_DATA_W, 32'd0);
    check("shr rst valid", {31'b0, bus.LOAD_VALID_W}, 32'd0);
    check("shr rst misalign", {31'b0, bus.MISALIGN_W}, 32'd0);
`ifdef LSU_PERF_EN
    check("shr rst rmw_cnt", {16'h0, bus.RMW_COUNT}, 32'd0);
    check("shr rst mis_cnt", {16'h0, bus.MISALIGN_COUNT}, 32'd0);
`endif
    @(posedge CLK);
    #1;
    check("shr mem0", mem[0], 32'h0000_ABE8);
    @(negedge CLK);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    RST_N = 1'b1;
    #1;
    check("shr idle we", {31'b0, bus.DM_WE}, 32'd0);
    @(posedge CLK);
    #1;
    check("shr idle we2", {31'b0, bus.DM_WE}, 32'd0);
    check("shr idle stall", {31'b0, bus.STALL}, 32'd0);
    check("shr mem0 final", mem[0], 32'h0000_ABE8);
    load_chk("lw 0 after rst", 3'b010, 32'h0, 32'h0000_ABE8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
